// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared definitions for the 4x4 keypad scanner: geometry, key codes,
// default timing, scan FSM states and key-bitmap helper functions.
package keypad_scan_ctrl_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    // Dwell per row in hwclk cycles (1 ms at 12 MHz) and frames of agreement.
    localparam int DEFAULT_SCAN_DIV       = 12000;
    localparam int DEFAULT_DEBOUNCE_SCANS = 4;

    // Key codes: row*4 + col.
    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    typedef enum logic [0:0] {
        ST_DRIVE  = 1'b0,
        ST_SAMPLE = 1'b1
    } scan_state_t;

    // True when exactly one key is down in the bitmap.
    function automatic logic single_key(input logic [15:0] keys);
        return (keys != 16'h0000) && ((keys & (keys - 16'h0001)) == 16'h0000);
    endfunction

    // Index of the highest set bit; meaningful when single_key() holds.
    function automatic logic [3:0] key_index(input logic [15:0] keys);
        logic [3:0] idx;
        idx = KEY_0;
        for (int i = 0; i < 16; i++) begin
            if (keys[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_debounce.sv
// Whole-keypad debouncer: a new snapshot is accepted only after it has been
// seen in DEBOUNCE_SCANS consecutive frames; a one-cycle strobe marks the update.
module keypad_debounce
    import keypad_scan_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = DEFAULT_DEBOUNCE_SCANS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] snapshot,
    input  logic                frame_done,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                update
);

    localparam int SW = $clog2(DEBOUNCE_SCANS);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS - 1);
    localparam logic [SW-1:0] STABLE_PRE = SW'(DEBOUNCE_SCANS - 2);

    logic [NUM_KEYS-1:0] prev_snap_r;
    logic [NUM_KEYS-1:0] key_state_r;
    logic [SW-1:0]       stable_cnt_r;
    logic                update_r;

    // Compare each finished frame with the previous one; commit once the agreement count reaches its top.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_snap_r  <= {NUM_KEYS{1'b0}};
            key_state_r  <= {NUM_KEYS{1'b0}};
            stable_cnt_r <= {SW{1'b0}};
            update_r     <= 1'b0;
        end else begin
            update_r <= 1'b0;
            if (frame_done) begin
                prev_snap_r <= snapshot;
                if (snapshot == prev_snap_r) begin
                    if (stable_cnt_r != STABLE_MAX) begin
                        stable_cnt_r <= stable_cnt_r + SW'(1);
                    end
                    // Only the step into saturation commits; saturated frames stay quiet.
                    if (stable_cnt_r == STABLE_PRE) begin
                        key_state_r <= snapshot;
                        update_r    <= 1'b1;
                    end
                end else begin
                    stable_cnt_r <= {SW{1'b0}};
                end
            end
        end
    end

    assign key_state = key_state_r;
    assign update    = update_r;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row scanner: drives one row low at a time, samples the columns
// through a 2-flop synchronizer, debounces full-frame snapshots and emits a
// one-cycle strobe with the key code for each clean single-key press.
module keypad_scan_ctrl
    import keypad_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV       = DEFAULT_SCAN_DIV,
    parameter int DEBOUNCE_SCANS = DEFAULT_DEBOUNCE_SCANS
) (
    input  logic                hwclk,
    input  logic                rst,
    output logic [3:0]          keypad_r,
    input  logic [3:0]          keypad_c,
    output logic                key_valid,
    output logic [3:0]          key_code,
    output logic                key_held,
    output logic [NUM_KEYS-1:0] key_state
);

    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    scan_state_t         state_r;
    logic [1:0]          row_r;
    logic [DW-1:0]       dwell_r;
    logic [3:0]          row_drive_r;
    logic [NUM_KEYS-1:0] snapshot_r;
    logic                frame_done_r;
    logic [3:0]          col_meta_r;
    logic [3:0]          col_sync_r;
    logic                key_valid_r;
    logic [3:0]          key_code_r;
    logic                key_held_r;
    logic [NUM_KEYS-1:0] key_state_s;
    logic                update_s;

    // Two-stage synchronizer for the asynchronous column pads (idle high).
    always_ff @(posedge hwclk) begin
        if (rst) begin
            col_meta_r <= 4'b1111;
            col_sync_r <= 4'b1111;
        end else begin
            col_meta_r <= keypad_c;
            col_sync_r <= col_meta_r;
        end
    end

    // Scan FSM: dwell on each row, then sample its columns for one cycle and advance.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            state_r      <= ST_DRIVE;
            row_r        <= 2'd0;
            dwell_r      <= {DW{1'b0}};
            row_drive_r  <= 4'b1110;
            snapshot_r   <= {NUM_KEYS{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                ST_DRIVE: begin
                    dwell_r <= dwell_r + DW'(1);
                    if (dwell_r == DWELL_LAST) begin
                        state_r <= ST_SAMPLE;
                    end else begin
                        state_r <= ST_DRIVE;
                    end
                end
                ST_SAMPLE: begin
                    snapshot_r[{row_r, 2'b00} +: 4] <= ~col_sync_r;
                    dwell_r      <= {DW{1'b0}};
                    // 2-bit row wraps from 3 back to 0 at the end of a frame.
                    row_r        <= row_r + 2'd1;
                    row_drive_r  <= ~(4'b0001 << (row_r + 2'd1));
                    frame_done_r <= (row_r == 2'd3);
                    state_r      <= ST_DRIVE;
                end
                default: begin
                    state_r <= ST_DRIVE;
                    dwell_r <= {DW{1'b0}};
                end
            endcase
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (hwclk),
        .rst        (rst),
        .snapshot   (snapshot_r),
        .frame_done (frame_done_r),
        .key_state  (key_state_s),
        .update     (update_s)
    );

    // Press-event encoder; key_held lags key_state by one cycle, so during the
    // update strobe it still describes the state before the update.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            key_valid_r <= 1'b0;
            key_code_r  <= KEY_0;
            key_held_r  <= 1'b0;
        end else begin
            key_held_r <= (key_state_s != {NUM_KEYS{1'b0}});
            if (update_s && !key_held_r && single_key(key_state_s)) begin
                key_valid_r <= 1'b1;
                key_code_r  <= key_index(key_state_s);
            end else begin
                key_valid_r <= 1'b0;
            end
        end
    end

    assign keypad_r  = row_drive_r;
    assign key_valid = key_valid_r;
    assign key_code  = key_code_r;
    assign key_held  = key_held_r;
    assign key_state = key_state_s;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV = 4, DEBOUNCE_SCANS = 3.
// A behavioural keypad matrix pulls a column low when its key is pressed and
// its row is driven low.
module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV = 4;
    localparam int FRAME    = 4 * (SCAN_DIV + 1);

    logic        hwclk = 1'b0;
    logic        rst   = 1'b1;
    logic [3:0]  keypad_r;
    logic [3:0]  keypad_c;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] key_state;

    logic [15:0] pressed = 16'h0000;

    int          n_checks  = 0;
    int          n_pass    = 0;
    int          pulse_cnt = 0;
    logic [3:0]  last_code = 4'h0;
    int          ks_dirty  = 0;

    keypad_scan_ctrl #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .hwclk     (hwclk),
        .rst       (rst),
        .keypad_r  (keypad_r),
        .keypad_c  (keypad_c),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held),
        .key_state (key_state)
    );

    always #5 hwclk = ~hwclk;

    // Keypad matrix model: pressed keys in a low-driven row pull their column low.
    always_comb begin
        keypad_c = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (keypad_r[r] == 1'b0) begin
                keypad_c = keypad_c & ~pressed[r*4 +: 4];
            end
        end
    end

    // Pulse and key_state activity monitor.
    always @(negedge hwclk) begin
        if (key_valid === 1'b1) begin
            pulse_cnt = pulse_cnt + 1;
            last_code = key_code;
        end
        if (key_state !== 16'h0000 && rst === 1'b0) begin
            ks_dirty = ks_dirty + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_frames(input int n);
        repeat (n * FRAME) @(negedge hwclk);
    endtask

    initial begin
        int         base;
        int         dbase;
        int         found;
        logic [3:0] exp_row;

        // 1: reset, then idle row sequence with 5 cycles per row
        repeat (3) @(negedge hwclk);
        check_eq("rst_valid", 32'(key_valid), 32'h0);
        check_eq("rst_code",  32'(key_code),  32'h0);
        check_eq("rst_held",  32'(key_held),  32'h0);
        check_eq("rst_state", 32'(key_state), 32'h0);
        rst = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            if (k != 0) @(negedge hwclk);
            exp_row = ~(4'b0001 << ((k / 5) % 4));
            check_eq("row_seq", 32'(keypad_r), 32'(exp_row));
        end
        wait_frames(3);
        check_eq("idle_pulses", 32'(pulse_cnt), 32'h0);
        check_eq("idle_state",  32'(key_state), 32'h0);

        // 2: clean press of key 6, then release
        base = pulse_cnt;
        pressed = 16'h0040;
        wait_frames(5);
        check_eq("k6_pulses", 32'(pulse_cnt - base), 32'h1);
        check_eq("k6_code",   32'(last_code),        32'h6);
        check_eq("k6_state",  32'(key_state),        32'h0040);
        check_eq("k6_held",   32'(key_held),         32'h1);
        pressed = 16'h0000;
        wait_frames(5);
        check_eq("k6_rel_pulses", 32'(pulse_cnt - base), 32'h1);
        check_eq("k6_rel_state",  32'(key_state),        32'h0);
        check_eq("k6_rel_held",   32'(key_held),         32'h0);

        // 3: key 6 bouncing every 7 cycles, then released
        base  = pulse_cnt;
        dbase = ks_dirty;
        repeat (12) begin
            pressed[6] = ~pressed[6];
            repeat (7) @(negedge hwclk);
        end
        pressed = 16'h0000;
        wait_frames(5);
        check_eq("bounce_pulses", 32'(pulse_cnt - base), 32'h0);
        check_eq("bounce_dirty",  32'(ks_dirty - dbase), 32'h0);
        check_eq("bounce_state",  32'(key_state),        32'h0);

        // 4: two-key chord 0 + 15, then release
        base = pulse_cnt;
        pressed = 16'h8001;
        wait_frames(5);
        check_eq("chord_pulses", 32'(pulse_cnt - base), 32'h0);
        check_eq("chord_state",  32'(key_state),        32'h8001);
        check_eq("chord_held",   32'(key_held),         32'h1);
        pressed = 16'h0000;
        wait_frames(5);
        check_eq("chord_rel_pulses", 32'(pulse_cnt - base), 32'h0);
        check_eq("chord_rel_held",   32'(key_held),         32'h0);
        check_eq("chord_rel_state",  32'(key_state),        32'h0);

        // 5: key 9 pressed, reset pulse mid-frame 2, measured latency afterwards
        base = pulse_cnt;
        pressed = 16'h0200;
        repeat (30) @(negedge hwclk);
        rst = 1'b1;
        @(negedge hwclk);
        rst = 1'b0;
        check_eq("mid_rst_row",   32'(keypad_r),  32'he);
        check_eq("mid_rst_valid", 32'(key_valid), 32'h0);
        check_eq("mid_rst_code",  32'(key_code),  32'h0);
        check_eq("mid_rst_held",  32'(key_held),  32'h0);
        check_eq("mid_rst_state", 32'(key_state), 32'h0);
        found = 0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(posedge hwclk);
            #1;
            if (key_valid === 1'b1 && found == 0) found = cyc;
        end
        check_eq("k9_latency", 32'(found),            32'd62);
        check_eq("k9_code",    32'(key_code),         32'h9);
        check_eq("k9_pulses",  32'(pulse_cnt - base), 32'h1);
        check_eq("k9_state",   32'(key_state),        32'h0200);

        // 6: key 3 pressed, released, pressed again
        pressed = 16'h0000;
        wait_frames(5);
        base = pulse_cnt;
        pressed = 16'h0008;
        wait_frames(5);
        check_eq("k3_first", 32'(pulse_cnt - base), 32'h1);
        pressed = 16'h0000;
        wait_frames(5);
        check_eq("k3_rel_held", 32'(key_held), 32'h0);
        pressed = 16'h0008;
        wait_frames(5);
        check_eq("k3_pulses", 32'(pulse_cnt - base), 32'h2);
        check_eq("k3_code",   32'(last_code),        32'h3);
        check_eq("k3_held",   32'(key_held),         32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
